// File: rtl/plane_spawner.sv
// plane_spawner
//   Keeps a fixed pool of plane slots for the difficulty controller's game
//   loop. Every movement tick it moves active planes down the playfield, frees
//   planes that leave the bottom, spawns at most one new plane when the pool
//   is below target, and then streams every active plane to the VGA drawer.
//
// Ports
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   enable        1 = run, 0 = freeze all state (plane_ready ignored)
//   plane_amount  target active planes, clamped to 1..SLOTS
//   flying_rate   speed level, step = flying_rate + 1 pixels per tick
//   plane_x/y     coordinates of the presented plane
//   plane_slot    slot index of the presented plane
//   plane_valid   presented plane fields are valid
//   plane_ready   drawer accepts the presented plane
//   frame_done    one-cycle pulse after the last plane of a pass
//   escaped       one-cycle pulse per plane freed at the bottom
//   active_count  number of active slots
//
// Optional feature macro: PLANE_SPAWNER_ESCAPE_CNT_EN
//   When defined, adds escape_count[7:0], a saturating count of escapes.
module plane_spawner #(
  parameter int SLOTS     = 10,
  parameter int TICK_DIV  = 50000,
  parameter int SPAWN_GAP = 4,
  parameter int SCREEN_H  = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [3:0] plane_amount,
  input  logic [1:0] flying_rate,
  output logic [7:0] plane_x,
  output logic [6:0] plane_y,
  output logic [3:0] plane_slot,
  output logic       plane_valid,
  input  logic       plane_ready,
  output logic       frame_done,
  output logic       escaped,
`ifdef PLANE_SPAWNER_ESCAPE_CNT_EN
  output logic [7:0] escape_count,
`endif
  output logic [3:0] active_count
);

  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW0 = $clog2(SPAWN_GAP + 1);
  localparam int GW  = (GW0 < 1) ? 1 : GW0;

  typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_SPAWN, S_EMIT, S_DONE} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_presc;
  logic             r_pending;
  logic [15:0]      r_lfsr;
  logic [3:0]       r_idx;
  logic [SLOTS-1:0] r_active;
  logic [7:0]       r_x [SLOTS];
  logic [6:0]       r_y [SLOTS];
  logic [GW-1:0]    r_gap;
  logic [3:0]       r_count;
  logic             r_valid;
  logic [7:0]       r_px;
  logic [6:0]       r_py;
  logic [3:0]       r_pslot;
  logic             r_frame_done;
  logic             r_escaped;
`ifdef PLANE_SPAWNER_ESCAPE_CNT_EN
  logic [7:0]       r_esc_cnt;
`endif

  logic       w_tick;
  logic       w_last;
  logic [7:0] w_ynext;
  logic       w_escape;
  logic [3:0] w_target;
  logic [3:0] w_free_idx;
  logic       w_lfsr_fb;

  assign w_tick    = enable && (r_presc == PW'(TICK_DIV - 1));
  assign w_last    = (r_idx == 4'(SLOTS - 1));
  // 8-bit sum: y never exceeds SCREEN_H-1 and step is at most 4
  assign w_ynext   = {1'b0, r_y[r_idx]} + {6'd0, flying_rate} + 8'd1;
  assign w_escape  = (w_ynext >= 8'(SCREEN_H));
  // Fibonacci taps 16,14,13,11 with bit 0 as the output end
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_comb begin
    w_target = plane_amount;
    if (plane_amount == 4'd0)
      w_target = 4'd1;
    else if (plane_amount > 4'(SLOTS))
      w_target = 4'(SLOTS);
  end

  // Lowest-index free slot; scanning downward lets the lowest match win
  always_comb begin
    w_free_idx = 4'd0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_active[i]) w_free_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
      r_lfsr  <= 16'hACE1;
    end else if (enable) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_lfsr  <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_idx        <= '0;
      r_active     <= '0;
      r_gap        <= GW'(SPAWN_GAP);
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_px         <= '0;
      r_py         <= '0;
      r_pslot      <= '0;
      r_frame_done <= 1'b0;
      r_escaped    <= 1'b0;
`ifdef PLANE_SPAWNER_ESCAPE_CNT_EN
      r_esc_cnt    <= '0;
`endif
      for (int i = 0; i < SLOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else if (enable) begin
      r_frame_done <= 1'b0;
      r_escaped    <= 1'b0;
      if (w_tick) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          // A tick landing in the same cycle is dropped: the flag is already set
          if (r_pending) begin
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_state   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (r_active[r_idx]) begin
            if (w_escape) begin
              r_active[r_idx] <= 1'b0;
              r_escaped       <= 1'b1;
              r_count         <= r_count - 1'b1;
`ifdef PLANE_SPAWNER_ESCAPE_CNT_EN
              if (r_esc_cnt != 8'hFF) r_esc_cnt <= r_esc_cnt + 1'b1;
`endif
            end else begin
              r_y[r_idx] <= w_ynext[6:0];
            end
          end
          if (w_last) r_state <= S_SPAWN;
          else        r_idx   <= r_idx + 1'b1;
        end
        S_SPAWN: begin
          // Pools above target are left to drain by escaping
          if ((r_count < w_target) && (r_gap >= GW'(SPAWN_GAP))) begin
            r_active[w_free_idx] <= 1'b1;
            r_y[w_free_idx]      <= '0;
            r_x[w_free_idx]      <= {1'b0, r_lfsr[6:0]} + 8'd16;
            r_gap                <= '0;
            r_count              <= r_count + 1'b1;
          end else if (r_gap < GW'(SPAWN_GAP)) begin
            r_gap <= r_gap + 1'b1;
          end
          r_idx   <= '0;
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (r_valid) begin
            if (plane_ready) begin
              r_valid <= 1'b0;
              if (w_last) begin
                r_state      <= S_DONE;
                r_frame_done <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end else if (r_active[r_idx]) begin
            r_valid <= 1'b1;
            r_px    <= r_x[r_idx];
            r_py    <= r_y[r_idx];
            r_pslot <= r_idx;
          end else if (w_last) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign plane_x      = r_px;
  assign plane_y      = r_py;
  assign plane_slot   = r_pslot;
  assign plane_valid  = r_valid;
  assign frame_done   = r_frame_done;
  assign escaped      = r_escaped;
  assign active_count = r_count;
`ifdef PLANE_SPAWNER_ESCAPE_CNT_EN
  assign escape_count = r_esc_cnt;
`endif

endmodule
